bank_arbiter: RTL and testbench
===============================

BANK_ARBITER -- requirements
Module: bank_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, number of requesting cores.
REQ-002 SHALL have parameter ADDR_W, default 8, bank address width.
REQ-003 SHALL have parameter DATA_W, default 8, bank data width.
REQ-004 clk  in  1  single clock; all logic on posedge.
REQ-005 reset  in  1  asynchronous, active-low; the block is in reset while reset=0.
REQ-006 req_valid  in  NUM_PORTS  per-port request pending.
REQ-007 req_we  in  NUM_PORTS  per-port: 1=write, 0=read.
REQ-008 req_addr  in  NUM_PORTS*ADDR_W  per-port address; port i occupies bits [i*ADDR_W +: ADDR_W].
REQ-009 req_wdata  in  NUM_PORTS*DATA_W  per-port write data, packed the same way.
REQ-010 req_ready  out  NUM_PORTS  one-hot grant, combinational.
REQ-011 resp_valid  out  1  response strobe, one cycle.
REQ-012 resp_id  out  log2(NUM_PORTS)  port that owns the response.
REQ-013 resp_we  out  1  response is a write acknowledge.
REQ-014 resp_data  out  DATA_W  read data.
REQ-015 resp_hit  out  1  bank valid flag for the read; 1 for write acks.
REQ-016 bank_addr, bank_data_in  out  ADDR_W, DATA_W  registered bank address and write data.
REQ-017 bank_read_enable, bank_write_enable  out  1 each  registered bank strobes.
REQ-018 bank_data_out, bank_valid_out  in  DATA_W, 1  bank read result, valid one cycle after the strobe.

Function
REQ-019 req_ready[i] SHALL be 1 only for the first port at or after rr_ptr, in circular order, that has req_valid=1; all other bits are 0.
REQ-020 A transfer occurs on an edge where req_valid[i] & req_ready[i]; a requester SHALL hold valid, we, addr and wdata stable until that edge.
REQ-021 On a transfer from port k, rr_ptr SHALL become (k+1) mod NUM_PORTS; with no transfer, rr_ptr is unchanged.
REQ-022 Stage 1 (issue): on the transfer edge, the block SHALL register addr and wdata into bank_addr and bank_data_in, and assert exactly one bank strobe for one cycle.
REQ-023 bank_read_enable and bank_write_enable SHALL never be 1 in the same cycle.
REQ-024 Stage 2 (wait): the block SHALL carry id and we one cycle alongside the bank access.
REQ-025 Stage 3 (respond): on the following edge, the block SHALL register bank_data_out and bank_valid_out, or data=0 and hit=1 for a write, and assert resp_valid for one cycle.
REQ-026 Latency SHALL be fixed: a transfer on edge E gives resp_valid high in the cycle after edge E+2.
REQ-027 Responses SHALL be returned in grant order.
REQ-028 One transfer per cycle SHALL be accepted back-to-back with no bubbles, giving a throughput of 1 per cycle.
REQ-029 When there is no transfer, both bank strobes SHALL be 0 and bank_addr and bank_data_in SHALL hold their previous values.
REQ-030 resp_data and resp_id SHALL hold their last values while resp_valid=0.
REQ-031 A read following a write to the same address on the next cycle SHALL return the new data (the bank orders them through the serial pipeline).

Reset
REQ-032 While reset=0, the block SHALL force rr_ptr=0 and clear both pipeline valid bits.
REQ-033 While reset=0, the block SHALL drive all bank strobes=0, bank_addr=0, bank_data_in=0, resp_valid=0, resp_id=0, resp_we=0, resp_data=0 and resp_hit=0.
REQ-034 Reset mid-operation SHALL discard every in-flight transaction with no response.
REQ-035 While reset=0, req_ready SHALL be all-zero.
REQ-036 The first transfer after reset release SHALL occur no earlier than the first posedge with reset=1.

Structure
REQ-037 NUM_PORTS, ADDR_W and DATA_W defaults and the port-id width SHALL live in the shared memory package used by the bank and this block.
REQ-038 The round-robin grant logic SHALL be a separate sub-module rr_arbiter with ports req, ptr and grant.
REQ-039 The pipeline registers SHALL remain in bank_arbiter.

Verification
REQ-040 Single read: hold port 2 read to addr 0x10 on an unwritten bank -> resp_valid in the 3rd cycle after the request is presented, with resp_id=2, resp_we=0 and resp_hit=0.
REQ-041 Write then read: port 0 writes 0xA5 to 0x33, then port 1 reads 0x33 on the next cycle -> write ack with id=0 and hit=1, then a read response with data=0xA5, hit=1 and id=1.
REQ-042 Fairness: all 4 ports hold req_valid=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, and 8 responses in the same order.
REQ-043 Pointer skip: rr_ptr=1 and only ports 0 and 3 valid -> port 3 granted first, then port 0, and the next rr_ptr=1.
REQ-044 Reset mid-flight: assert reset for 1 cycle one cycle after a read transfer -> no resp_valid, all outputs 0, and the next grant goes to port 0.
REQ-045 Idle: no req_valid for 10 cycles -> both bank strobes stay 0, resp_valid stays 0, and bank_addr is unchanged.

Source files
------------

// File: rtl/bank_arbiter_pkg.sv
// Shared memory-subsystem constants: default port count, bank address/data widths
// and the port-id width helper used by the bank and its arbiter.
package bank_arbiter_pkg;

  localparam int NUM_PORTS_DEF = 4;
  localparam int ADDR_W_DEF    = 8;
  localparam int DATA_W_DEF    = 8;

  // Port-id width; a single-port build still needs a 1-bit id field.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bank_arbiter_rr.sv
// Round-robin grant: one-hot grant to the first requesting port at or after ptr,
// searching in circular order. Purely combinational.
module rr_arbiter
  import bank_arbiter_pkg::*;
#(
  parameter int N = NUM_PORTS_DEF,
  localparam int PW = id_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic          found;
  int            idx;
  logic [PW-1:0] sel;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    sel   = '0;
    for (int off = 0; off < N; off++) begin
      idx = int'(ptr) + off;
      if (idx >= N) idx = idx - N;
      sel = PW'(idx);
      if (!found && req[sel]) begin
        grant[sel] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bank_arbiter.sv
// Multi-port bank arbiter: round-robin grant, then a fixed 3-stage pipeline
// (issue -> wait -> respond) to a single-ported bank with 1-cycle read latency.
//
// Handshake: a transfer happens on a rising edge where req_valid[i] & req_ready[i];
// the requester keeps valid/we/addr/wdata stable until that edge. req_ready is a
// combinational one-hot grant and never depends on req_ready itself.
module bank_arbiter
  import bank_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  localparam int ID_W     = id_width(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PORTS-1:0]        req_valid,
  input  logic [NUM_PORTS-1:0]        req_we,
  input  logic [NUM_PORTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_PORTS*DATA_W-1:0] req_wdata,
  output logic [NUM_PORTS-1:0]        req_ready,
  output logic                        resp_valid,
  output logic [ID_W-1:0]             resp_id,
  output logic                        resp_we,
  output logic [DATA_W-1:0]           resp_data,
  output logic                        resp_hit,
  output logic [ADDR_W-1:0]           bank_addr,
  output logic [DATA_W-1:0]           bank_data_in,
  output logic                        bank_read_enable,
  output logic                        bank_write_enable,
  input  logic [DATA_W-1:0]           bank_data_out,
  input  logic                        bank_valid_out,
  output logic [ID_W-1:0]             dbg_rr_ptr
);

  logic [ID_W-1:0]      rr_ptr;
  logic [NUM_PORTS-1:0] grant;
  logic                 xfer;
  logic [ID_W-1:0]      xfer_id;
  logic                 sel_we;
  logic [ADDR_W-1:0]    sel_addr;
  logic [DATA_W-1:0]    sel_wdata;
  logic [ID_W-1:0]      ptr_next;

  logic                 s1_valid;
  logic [ID_W-1:0]      s1_id;
  logic                 s1_we;
  logic                 s2_valid;
  logic [ID_W-1:0]      s2_id;
  logic                 s2_we;

  rr_arbiter #(.N(NUM_PORTS)) u_rr (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Grants are masked while in reset so nothing can transfer before release.
  assign req_ready  = grant & {NUM_PORTS{reset}};
  assign xfer       = |req_ready;
  assign dbg_rr_ptr = rr_ptr;

  always_comb begin
    xfer_id   = '0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (req_ready[i]) begin
        xfer_id   = ID_W'(i);
        sel_we    = req_we[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    ptr_next = xfer_id + ID_W'(1);
    if (xfer_id == ID_W'(NUM_PORTS - 1)) ptr_next = '0;
  end

  // Issue stage plus pointer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr            <= '0;
      bank_addr         <= '0;
      bank_data_in      <= '0;
      bank_read_enable  <= 1'b0;
      bank_write_enable <= 1'b0;
      s1_valid          <= 1'b0;
      s1_id             <= '0;
      s1_we             <= 1'b0;
    end else begin
      bank_read_enable  <= xfer & ~sel_we;
      bank_write_enable <= xfer & sel_we;
      s1_valid          <= xfer;
      if (xfer) begin
        rr_ptr       <= ptr_next;
        bank_addr    <= sel_addr;
        bank_data_in <= sel_wdata;
        s1_id        <= xfer_id;
        s1_we        <= sel_we;
      end
    end
  end

  // Wait stage: the tag rides alongside the bank access while the bank reads.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid <= 1'b0;
      s2_id    <= '0;
      s2_we    <= 1'b0;
    end else begin
      s2_valid <= s1_valid;
      s2_id    <= s1_id;
      s2_we    <= s1_we;
    end
  end

  // Respond stage: payload registers only load on a real response so they hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_we    <= 1'b0;
      resp_data  <= '0;
      resp_hit   <= 1'b0;
    end else begin
      resp_valid <= s2_valid;
      if (s2_valid) begin
        resp_id   <= s2_id;
        resp_we   <= s2_we;
        resp_data <= s2_we ? '0 : bank_data_out;
        resp_hit  <= s2_we | bank_valid_out;
      end
    end
  end

endmodule

// File: tb/tb_bank_arbiter.sv
// Bench for bank_arbiter: behavioural bank, per-port requesters, and a scoreboard
// that predicts grants and responses from the arbitration and ordering rules.
module tb_bank_arbiter;

  localparam int NP = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int IW = 2;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NP-1:0]    req_valid, req_we, req_ready;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wdata;
  logic             resp_valid, resp_we, resp_hit;
  logic [IW-1:0]    resp_id, dbg_rr_ptr;
  logic [DW-1:0]    resp_data, bank_data_in;
  logic [AW-1:0]    bank_addr;
  logic             bank_read_enable, bank_write_enable;
  logic [DW-1:0]    bank_data_out  = '0;
  logic             bank_valid_out = 1'b0;

  bank_arbiter dut (
    .clk               (clk),
    .reset             (reset),
    .req_valid         (req_valid),
    .req_we            (req_we),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .req_ready         (req_ready),
    .resp_valid        (resp_valid),
    .resp_id           (resp_id),
    .resp_we           (resp_we),
    .resp_data         (resp_data),
    .resp_hit          (resp_hit),
    .bank_addr         (bank_addr),
    .bank_data_in      (bank_data_in),
    .bank_read_enable  (bank_read_enable),
    .bank_write_enable (bank_write_enable),
    .bank_data_out     (bank_data_out),
    .bank_valid_out    (bank_valid_out),
    .dbg_rr_ptr        (dbg_rr_ptr)
  );

  // Behavioural bank: result one cycle after the read strobe, valid flag per word.
  logic [DW-1:0] bank_mem [256] = '{default: '0};
  logic          bank_vld [256] = '{default: 1'b0};
  always @(posedge clk) begin
    bank_valid_out <= 1'b0;
    if (bank_write_enable) begin
      bank_mem[bank_addr] <= bank_data_in;
      bank_vld[bank_addr] <= 1'b1;
    end
    if (bank_read_enable) begin
      bank_data_out  <= bank_mem[bank_addr];
      bank_valid_out <= bank_vld[bank_addr];
    end
  end

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [31:0]   due;
    logic [IW-1:0] id;
    logic          we;
    logic          hit;
    logic [DW-1:0] data;
  } exp_t;
  exp_t exp_q[$];

  logic [DW-1:0] m_mem [256] = '{default: '0};
  logic          m_vld [256] = '{default: 1'b0};
  int            m_ptr;
  logic          m_rd, m_wr;
  logic [AW-1:0] m_baddr;
  logic [DW-1:0] m_bdin, m_rdata;
  logic [IW-1:0] m_rid;

  logic          p_valid [NP];
  logic          p_we    [NP];
  logic [AW-1:0] p_addr  [NP];
  logic [DW-1:0] p_wdata [NP];

  logic          obs_rv, obs_we, obs_hit, obs_rd, obs_wr;
  logic [IW-1:0] obs_id;
  logic [DW-1:0] obs_data;
  logic [AW-1:0] obs_baddr;
  logic [NP-1:0] obs_ready;

  int n_vec = 0;
  int n_err = 0;

  task automatic model_reset();
    m_ptr   = 0;
    m_rd    = 1'b0;
    m_wr    = 1'b0;
    m_baddr = '0;
    m_bdin  = '0;
    m_rdata = '0;
    m_rid   = '0;
    exp_q.delete();
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < NP; p++) begin
      req_valid[p]            = p_valid[p];
      req_we[p]               = p_we[p];
      req_addr[p*AW +: AW]    = p_addr[p];
      req_wdata[p*DW +: DW]   = p_wdata[p];
    end
  endtask

  task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    p_valid[p] = 1'b1;
    p_we[p]    = we;
    p_addr[p]  = a;
    p_wdata[p] = d;
  endtask

  // One clock cycle: score outputs of the last edge, drive requests, predict the grant.
  task automatic step();
    int            g;
    exp_t          e;
    logic [NP-1:0] exp_ready;
    @(negedge clk);
    obs_rv = resp_valid; obs_id = resp_id; obs_we = resp_we; obs_data = resp_data;
    obs_hit = resp_hit; obs_rd = bank_read_enable; obs_wr = bank_write_enable; obs_baddr = bank_addr;
    n_vec++;
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL resp_unexpected: got id=%0d we=%0d at cycle %0d, required no response", resp_id, resp_we, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({resp_id, resp_we, resp_hit, resp_data} !== {e.id, e.we, e.hit, e.data} || cyc != int'(e.due)) begin
          n_err++;
          $display("FAIL resp_value: got id=%0d we=%0d hit=%0d data=%h cyc=%0d, required id=%0d we=%0d hit=%0d data=%h cyc=%0d",
                   resp_id, resp_we, resp_hit, resp_data, cyc, e.id, e.we, e.hit, e.data, e.due);
        end
        m_rid   = e.id;
        m_rdata = e.data;
      end
    end else if (resp_id !== m_rid || resp_data !== m_rdata) begin
      n_err++;
      $display("FAIL resp_hold: got id=%0d data=%h, required id=%0d data=%h", resp_id, resp_data, m_rid, m_rdata);
    end
    n_vec++;
    if (exp_q.size() > 0 && int'(exp_q[0].due) <= cyc) begin
      n_err++;
      $display("FAIL resp_missing: no response for id=%0d due cycle %0d, now %0d", exp_q[0].id, exp_q[0].due, cyc);
      void'(exp_q.pop_front());
    end
    n_vec++;
    if ({bank_read_enable, bank_write_enable, bank_addr, bank_data_in} !== {m_rd, m_wr, m_baddr, m_bdin}) begin
      n_err++;
      $display("FAIL bank_issue: got rd=%0d wr=%0d addr=%h din=%h, required rd=%0d wr=%0d addr=%h din=%h",
               bank_read_enable, bank_write_enable, bank_addr, bank_data_in, m_rd, m_wr, m_baddr, m_bdin);
    end
    drive_inputs();
    #1;
    g = -1;
    for (int off = 0; off < NP; off++)
      if (g < 0 && p_valid[(m_ptr + off) % NP]) g = (m_ptr + off) % NP;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    obs_ready = req_ready;
    n_vec++;
    if (req_ready !== exp_ready || dbg_rr_ptr !== IW'(m_ptr)) begin
      n_err++;
      $display("FAIL grant: got ready=%b ptr=%0d, required ready=%b ptr=%0d", req_ready, dbg_rr_ptr, exp_ready, m_ptr);
    end
    m_rd = 1'b0;
    m_wr = 1'b0;
    if (g >= 0) begin
      e.due = 32'(cyc + 3);
      e.id  = IW'(g);
      e.we  = p_we[g];
      if (p_we[g]) begin
        e.hit = 1'b1;
        e.data = '0;
        m_mem[p_addr[g]] = p_wdata[g];
        m_vld[p_addr[g]] = 1'b1;
        m_wr = 1'b1;
      end else begin
        e.hit  = m_vld[p_addr[g]];
        e.data = m_mem[p_addr[g]];
        m_rd   = 1'b1;
      end
      exp_q.push_back(e);
      m_baddr    = p_addr[g];
      m_bdin     = p_wdata[g];
      m_ptr      = (g + 1) % NP;
      p_valid[g] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int p = 0; p < NP; p++) set_req(p, 1'b1, 8'(p), 8'hFF);
    drive_inputs();
    @(negedge clk);
    @(negedge clk);
    #1;
    n_vec++;
    if (req_ready !== '0) begin n_err++; $display("FAIL reset_ready: got %b, required 0000", req_ready); end
    n_vec++;
    if ({resp_valid, resp_id, resp_we, resp_data, resp_hit} !== '0) begin
      n_err++;
      $display("FAIL reset_resp: got v=%0d id=%0d we=%0d data=%h hit=%0d, required all 0", resp_valid, resp_id, resp_we, resp_data, resp_hit);
    end
    n_vec++;
    if ({bank_read_enable, bank_write_enable, bank_addr, bank_data_in} !== '0) begin
      n_err++;
      $display("FAIL reset_bank: got rd=%0d wr=%0d addr=%h din=%h, required all 0", bank_read_enable, bank_write_enable, bank_addr, bank_data_in);
    end
    n_vec++;
    if (dbg_rr_ptr !== '0) begin n_err++; $display("FAIL reset_ptr: got %0d, required 0", dbg_rr_ptr); end
    for (int p = 0; p < NP; p++) p_valid[p] = 1'b0;
    drive_inputs();
    model_reset();
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    drain(4);
    set_req(2, 1'b0, 8'h10, 8'h00);
    step();
    step();
    step();
    n_vec++;
    if (obs_rv !== 1'b0) begin n_err++; $display("FAIL single_early: got resp_valid=%0d, required 0", obs_rv); end
    step();
    n_vec++;
    if ({obs_rv, obs_id, obs_we, obs_hit} !== {1'b1, 2'd2, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL single_read: got v=%0d id=%0d we=%0d hit=%0d, required v=1 id=2 we=0 hit=0", obs_rv, obs_id, obs_we, obs_hit);
    end
  endtask

  task automatic test_write_then_read();
    drain(4);
    set_req(0, 1'b1, 8'h33, 8'hA5);
    step();
    set_req(1, 1'b0, 8'h33, 8'h00);
    step();
    step();
    step();
    n_vec++;
    if ({obs_rv, obs_id, obs_we, obs_hit, obs_data} !== {1'b1, 2'd0, 1'b1, 1'b1, 8'h00}) begin
      n_err++;
      $display("FAIL wr_ack: got v=%0d id=%0d we=%0d hit=%0d data=%h, required v=1 id=0 we=1 hit=1 data=00",
               obs_rv, obs_id, obs_we, obs_hit, obs_data);
    end
    step();
    n_vec++;
    if ({obs_rv, obs_id, obs_we, obs_hit, obs_data} !== {1'b1, 2'd1, 1'b0, 1'b1, 8'hA5}) begin
      n_err++;
      $display("FAIL rd_after_wr: got v=%0d id=%0d we=%0d hit=%0d data=%h, required v=1 id=1 we=0 hit=1 data=a5",
               obs_rv, obs_id, obs_we, obs_hit, obs_data);
    end
  endtask

  task automatic test_fairness();
    logic [NP-1:0] grants[$];
    int            rids[$];
    logic [NP-1:0] want;
    drain(4);
    set_req(3, 1'b0, 8'h40, 8'h00);
    step();
    drain(4);
    for (int c = 0; c < 16; c++) begin
      if (c < 8)
        for (int p = 0; p < NP; p++)
          if (!p_valid[p]) set_req(p, 1'($urandom_range(0, 1)), 8'h40 + 8'($urandom_range(0, 15)), 8'($urandom));
      step();
      if (obs_ready != '0) grants.push_back(obs_ready);
      if (obs_rv) rids.push_back(int'(obs_id));
    end
    for (int i = 0; i < 8; i++) begin
      want = '0;
      want[i % NP] = 1'b1;
      n_vec++;
      if (grants.size() <= i || grants[i] !== want) begin
        n_err++;
        $display("FAIL fair_grant[%0d]: got %b, required %b", i, (grants.size() > i) ? grants[i] : 4'b0, want);
      end
      n_vec++;
      if (rids.size() <= i || rids[i] != i % NP) begin
        n_err++;
        $display("FAIL fair_resp[%0d]: got id=%0d, required %0d", i, (rids.size() > i) ? rids[i] : -1, i % NP);
      end
    end
  endtask

  task automatic test_pointer_skip();
    drain(4);
    set_req(0, 1'b0, 8'h50, 8'h00);
    step();
    set_req(0, 1'b0, 8'h51, 8'h00);
    set_req(3, 1'b0, 8'h52, 8'h00);
    step();
    n_vec++;
    if (obs_ready !== 4'b1000) begin n_err++; $display("FAIL skip_first: got %b, required 1000", obs_ready); end
    step();
    n_vec++;
    if (obs_ready !== 4'b0001) begin n_err++; $display("FAIL skip_second: got %b, required 0001", obs_ready); end
    n_vec++;
    if (dbg_rr_ptr !== 2'd1) begin n_err++; $display("FAIL skip_ptr: got %0d, required 1", dbg_rr_ptr); end
  endtask

  task automatic test_idle();
    logic [AW-1:0] held;
    drain(4);
    held = m_baddr;
    for (int c = 0; c < 10; c++) begin
      step();
      n_vec++;
      if ({obs_rd, obs_wr, obs_rv} !== 3'b000 || obs_baddr !== held) begin
        n_err++;
        $display("FAIL idle[%0d]: got rd=%0d wr=%0d rv=%0d addr=%h, required 0 0 0 addr=%h", c, obs_rd, obs_wr, obs_rv, obs_baddr, held);
      end
    end
  endtask

  task automatic test_reset_mid_flight();
    drain(4);
    set_req(1, 1'b0, 8'h20, 8'h00);
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    req_valid = 4'b1111;
    #1;
    n_vec++;
    if (req_ready !== '0) begin n_err++; $display("FAIL mid_ready: got %b, required 0000", req_ready); end
    @(negedge clk);
    n_vec++;
    if ({resp_valid, resp_id, resp_we, resp_data, resp_hit, bank_read_enable, bank_write_enable, bank_addr, bank_data_in} !== '0) begin
      n_err++;
      $display("FAIL mid_outputs: got rv=%0d id=%0d rd=%0d wr=%0d addr=%h, required all 0", resp_valid, resp_id, bank_read_enable, bank_write_enable, bank_addr);
    end
    req_valid = '0;
    model_reset();
    reset = 1'b1;
    set_req(2, 1'b0, 8'h21, 8'h00);
    set_req(0, 1'b0, 8'h22, 8'h00);
    step();
    n_vec++;
    if (obs_ready !== 4'b0001) begin n_err++; $display("FAIL mid_next_grant: got %b, required 0001", obs_ready); end
    drain(6);
  endtask

  task automatic test_random();
    int guard;
    repeat (300) begin
      for (int p = 0; p < NP; p++)
        if (!p_valid[p] && $urandom_range(0, 2) != 0)
          set_req(p, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom));
      step();
    end
    guard = 0;
    while ((p_valid[0] | p_valid[1] | p_valid[2] | p_valid[3]) && guard < 20) begin
      step();
      guard++;
    end
    drain(5);
    n_vec++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL random_drain: got %0d outstanding, required 0", exp_q.size()); end
  endtask

  initial begin
    for (int p = 0; p < NP; p++) begin
      p_valid[p] = 1'b0; p_we[p] = 1'b0; p_addr[p] = '0; p_wdata[p] = '0;
    end
    drive_inputs();
    model_reset();
    test_reset();
    test_single_read();
    test_write_then_read();
    test_fairness();
    test_pointer_skip();
    test_idle();
    test_reset_mid_flight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
